// File: rtl/scr1_dmem_cnn_target_if.sv
// SCR1 dmem bus types and the request/response interface seen by the CNN target.
package scr1_cnn_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

interface scr1_dmem_cnn_target_if;

    logic                              req;
    logic                              req_ack;
    scr1_cnn_pkg::type_scr1_mem_cmd_e   cmd;
    scr1_cnn_pkg::type_scr1_mem_width_e width;
    logic [31:0]                       addr;
    logic [31:0]                       wdata;
    logic [31:0]                       rdata;
    scr1_cnn_pkg::type_scr1_mem_resp_e  resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );

endinterface

// File: rtl/scr1_dmem_cnn_target.sv
// SCR1 dmem responder for the CNN accelerator: control/status registers, two int8
// operand buffers and a 4-lane signed int8 dot-product engine.
// Optional feature macro: SCR1_CNN_SAT_EN (saturating accumulator with sticky OVF).
module scr1_dmem_cnn_target
    import scr1_cnn_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scr1_dmem_cnn_target_if.slave bus,
    output logic                  irq
);

    localparam int unsigned IW = $clog2(BUF_DEPTH);
    localparam int unsigned LW = $clog2(BUF_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Register state
    state_e              state_q, state_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic [LW-1:0]       len_q, len_d;
    logic [31:0]         acc_q, acc_d;
    logic [31:0]         result_q, result_d;
    logic                ie_q, ie_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                req_ack_q;
    type_scr1_mem_resp_e resp_q, resp_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                irq_q;

    logic [31:0] wbuf [BUF_DEPTH];
    logic [31:0] ibuf [BUF_DEPTH];

    // Decode signals
    logic [11:0]   off;
    logic          acc_req;
    logic          is_wr;
    logic          busy;
    logic          misalign_c;
    logic [3:0]    be_c;
    logic          idx_ok;
    logic          sel_reg;
    logic          sel_wbuf;
    logic          sel_ibuf;
    logic          err_c;
    logic [IW-1:0] buf_idx;
    logic [31:0]   rd_val_c;
    logic          wbuf_we;
    logic          ibuf_we;
    logic          unused_addr;

    // Engine datapath signals
    logic [LW-1:0]      eff_len;
    logic [31:0]        w_word;
    logic [31:0]        i_word;
    logic signed [15:0] prod;
    logic signed [17:0] lane_sum;
    logic [31:0]        acc_step_c;
    logic               step_ovf_c;

    assign off         = bus.addr[11:0];
    assign unused_addr = ^bus.addr[31:12];
    assign acc_req     = bus.req & req_ack_q;
    assign is_wr       = (bus.cmd == SCR1_MEM_CMD_WR);
    assign busy        = (state_q != ST_IDLE);
    assign buf_idx     = off[IW+1:2];
    assign idx_ok      = (32'(off[7:2]) < BUF_DEPTH);
    assign sel_reg     = (off[11:4] == 8'h00);
    assign sel_wbuf    = (off[11:8] == 4'h1) & idx_ok;
    assign sel_ibuf    = (off[11:8] == 4'h2) & idx_ok;
    assign eff_len     = (len_q > LW'(BUF_DEPTH)) ? LW'(BUF_DEPTH) : len_q;

    // Width/alignment check and byte enables for buffer writes
    always_comb begin
        misalign_c = 1'b0;
        be_c       = 4'b0000;
        case (bus.width)
            SCR1_MEM_WIDTH_BYTE:  be_c = 4'b0001 << off[1:0];
            SCR1_MEM_WIDTH_HWORD: begin
                misalign_c = off[0];
                be_c       = 4'b0011 << {off[1], 1'b0};
            end
            SCR1_MEM_WIDTH_WORD:  begin
                misalign_c = |off[1:0];
                be_c       = 4'b1111;
            end
            default:              misalign_c = 1'b1;
        endcase
    end

    // Error classification: any hit here leaves all state untouched
    assign err_c = misalign_c
                 | ~(sel_reg | sel_wbuf | sel_ibuf)
                 | (sel_reg & (bus.width != SCR1_MEM_WIDTH_WORD))
                 | (sel_reg & (off[3:2] == 2'd3) & is_wr)
                 | ((sel_wbuf | sel_ibuf) & busy);

    // Read data mux; registers see pre-update values of this cycle
    always_comb begin
        rd_val_c = '0;
        if (sel_wbuf) begin
            rd_val_c = wbuf[buf_idx];
        end else if (sel_ibuf) begin
            rd_val_c = ibuf[buf_idx];
        end else begin
            case (off[3:2])
                2'd0:    rd_val_c = {30'd0, ie_q, 1'b0};
                2'd1:    rd_val_c = {29'd0, ovf_q, done_q, busy};
                2'd2:    rd_val_c = 32'(len_q);
                default: rd_val_c = result_q;
            endcase
        end
    end

    // One dot-product step: four signed int8 products summed into 18 bits
    always_comb begin
        w_word   = wbuf[idx_q[IW-1:0]];
        i_word   = ibuf[idx_q[IW-1:0]];
        prod     = '0;
        lane_sum = '0;
        for (int b = 0; b < 4; b++) begin
            prod     = 16'($signed(w_word[8*b +: 8])) * 16'($signed(i_word[8*b +: 8]));
            lane_sum = lane_sum + {{2{prod[15]}}, prod};
        end
    end

`ifdef SCR1_CNN_SAT_EN
    logic [32:0] acc_wide;

    // Saturating accumulate with clamp detection
    always_comb begin
        acc_wide   = {acc_q[31], acc_q} + {{15{lane_sum[17]}}, lane_sum};
        step_ovf_c = (acc_wide[32] != acc_wide[31]);
        if (step_ovf_c) begin
            acc_step_c = acc_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            acc_step_c = acc_wide[31:0];
        end
    end
`else
    // Wrapping accumulate
    always_comb begin
        acc_step_c = acc_q + {{14{lane_sum[17]}}, lane_sum};
        step_ovf_c = 1'b0;
    end
`endif

    // Next state: bus side effects first, engine last so DONE set wins over W1C
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        acc_d    = acc_q;
        result_d = result_q;
        ie_d     = ie_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        resp_d   = SCR1_MEM_RESP_NOTRDY;
        rdata_d  = '0;
        wbuf_we  = 1'b0;
        ibuf_we  = 1'b0;

        if (acc_req) begin
            if (err_c) begin
                resp_d = SCR1_MEM_RESP_RDY_ER;
            end else begin
                resp_d = SCR1_MEM_RESP_RDY_OK;
                if (!is_wr) begin
                    rdata_d = rd_val_c;
                end else if (sel_wbuf) begin
                    wbuf_we = 1'b1;
                end else if (sel_ibuf) begin
                    ibuf_we = 1'b1;
                end else begin
                    case (off[3:2])
                        2'd0: if (!busy) begin
                            ie_d = bus.wdata[1];
                            if (bus.wdata[0]) begin
                                result_d = '0;
                                done_d   = 1'b0;
                                ovf_d    = 1'b0;
                                idx_d    = '0;
                                acc_d    = '0;
                                state_d  = (eff_len == '0) ? ST_DONE : ST_RUN;
                            end
                        end
                        2'd1: begin
                            if (bus.wdata[1]) done_d = 1'b0;
`ifdef SCR1_CNN_SAT_EN
                            if (bus.wdata[2]) ovf_d = 1'b0;
`endif
                        end
                        2'd2: if (!busy) len_d = bus.wdata[LW-1:0];
                        default: ;
                    endcase
                end
            end
        end

        case (state_q)
            ST_RUN: begin
                acc_d = acc_step_c;
                if (step_ovf_c) ovf_d = 1'b1;
                idx_d = idx_q + LW'(1);
                if ((idx_q + LW'(1)) >= eff_len) state_d = ST_DONE;
            end
            ST_DONE: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            req_ack_q <= 1'b1;
            resp_q    <= SCR1_MEM_RESP_NOTRDY;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            ie_q      <= ie_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            req_ack_q <= 1'b1;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            irq_q     <= done_d & ie_d;
        end
    end

    // Operand buffers: byte-enable writes, contents survive reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wbuf_we && be_c[b]) wbuf[buf_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            if (ibuf_we && be_c[b]) ibuf[buf_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
    end

    assign bus.req_ack = req_ack_q;
    assign bus.resp    = resp_q;
    assign bus.rdata   = rdata_q;
    assign irq         = irq_q;

endmodule
